// File: rtl/branch_history_table_if.sv
// rtl/branch_history_table_if.sv - ID/EX predictor signal bundle for the branch history table
interface branch_history_table_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  ID_pc_i;
    logic             ID_Branch_i;
    logic             ID_stall_i;
    logic             ID_flush_i;
    logic             predict_taken_o;
    logic [1:0]       EX_state_o;
    logic             EX_Branch_i;
    logic [1:0]       update_i;
    logic             rbk_i;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output ID_pc_i, ID_Branch_i, ID_stall_i, ID_flush_i,
        output EX_Branch_i, update_i, rbk_i,
        input  predict_taken_o, EX_state_o, branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  ID_pc_i, ID_Branch_i, ID_stall_i, ID_flush_i,
        input  EX_Branch_i, update_i, rbk_i,
        output predict_taken_o, EX_state_o, branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating predictor table with ID/EX carry and statistics
module branch_history_table #(
    parameter int         IDX_W       = 4,
    parameter int         PC_W        = 32,
    parameter logic [1:0] RESET_STATE = 2'b11,
    parameter int         CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    branch_history_table_if.slave  bus
);
    localparam int               DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       table_q [DEPTH];
    logic [1:0]       ex_state_q, ex_state_d;
    logic [IDX_W-1:0] ex_idx_q, ex_idx_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_state;
    logic             we;
    logic             unused_pc_bits;

    // Word-aligned index; upper PC bits alias by design.
    assign rd_idx         = bus.ID_pc_i[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.ID_pc_i[PC_W-1:IDX_W+2], bus.ID_pc_i[1:0]};
    assign we             = bus.EX_Branch_i & ex_valid_q;

    always_comb begin
        rd_state      = table_q[rd_idx];
        ex_state_d    = ex_state_q;
        ex_idx_d      = ex_idx_q;
        ex_valid_d    = 1'b0;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        // Same-cycle write to the entry being read must be visible to ID.
        if (we && (ex_idx_q == rd_idx)) begin
            rd_state = bus.update_i;
        end

        if (!(bus.ID_stall_i || bus.ID_flush_i)) begin
            ex_valid_d = bus.ID_Branch_i;
            ex_state_d = rd_state;
            ex_idx_d   = rd_idx;
        end

        if (we) begin
            if (branch_cnt_q != {CNT_W{1'b1}}) begin
                branch_cnt_d = branch_cnt_q + CNT_ONE;
            end
            if (bus.rbk_i && (mispred_cnt_q != {CNT_W{1'b1}})) begin
                mispred_cnt_d = mispred_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= RESET_STATE;
            end
            ex_state_q    <= RESET_STATE;
            ex_idx_q      <= '0;
            ex_valid_q    <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (we) begin
                table_q[ex_idx_q] <= bus.update_i;
            end
            ex_state_q    <= ex_state_d;
            ex_idx_q      <= ex_idx_d;
            ex_valid_q    <= ex_valid_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.predict_taken_o = bus.ID_Branch_i & rd_state[1];
    assign bus.EX_state_o      = ex_state_q;
    assign bus.branch_cnt_o    = branch_cnt_q;
    assign bus.mispred_cnt_o   = mispred_cnt_q;
endmodule

// File: tb/tb_branch_history_table.sv
// tb/tb_branch_history_table.sv - vector and scoreboard bench for branch_history_table
module tb_branch_history_table;
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    branch_history_table_if #(.PC_W(32), .CNT_W(16)) bi ();
    branch_history_table_if #(.PC_W(32), .CNT_W(2))  bs ();

    assign bs.ID_pc_i     = bi.ID_pc_i;
    assign bs.ID_Branch_i = bi.ID_Branch_i;
    assign bs.ID_stall_i  = bi.ID_stall_i;
    assign bs.ID_flush_i  = bi.ID_flush_i;
    assign bs.EX_Branch_i = bi.EX_Branch_i;
    assign bs.update_i    = bi.update_i;
    assign bs.rbk_i       = bi.rbk_i;

    branch_history_table #(.IDX_W(4), .PC_W(32), .RESET_STATE(2'b11), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .bus(bi.slave)
    );
    branch_history_table #(.IDX_W(4), .PC_W(32), .RESET_STATE(2'b11), .CNT_W(2)) u_dut_sat (
        .clk_i(clk), .rst_i(rst_i), .bus(bs.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic        idb, stall, flush, exb;
        logic [1:0]  upd;
        logic        rbk;
        logic        exp_pred;
        logic [1:0]  exp_ex;
        logic [15:0] exp_b, exp_m;
    } vec_t;

    typedef struct {
        logic [1:0]  ex;
        logic [15:0] b, m;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(input logic [31:0] pc, input logic idb, input logic stall,
                                input logic flush, input logic exb, input logic [1:0] upd,
                                input logic rbk, input logic exp_pred, input logic [1:0] exp_ex,
                                input logic [15:0] exp_b, input logic [15:0] exp_m);
        vec_t v;
        v.pc = pc; v.idb = idb; v.stall = stall; v.flush = flush; v.exb = exb;
        v.upd = upd; v.rbk = rbk; v.exp_pred = exp_pred; v.exp_ex = exp_ex;
        v.exp_b = exp_b; v.exp_m = exp_m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] pc, input logic idb, input logic stall,
                         input logic flush, input logic exb, input logic [1:0] upd,
                         input logic rbk);
        bi.ID_pc_i = pc; bi.ID_Branch_i = idb; bi.ID_stall_i = stall;
        bi.ID_flush_i = flush; bi.EX_Branch_i = exb; bi.update_i = upd; bi.rbk_i = rbk;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic rbk_pat [5];

        rst_i = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        do_reset();

        #1;
        chk("rst ex_state", 32'(bi.EX_state_o), 32'h3);
        chk("rst branch_cnt", 32'(bi.branch_cnt_o), 32'h0);
        chk("rst mispred_cnt", 32'(bi.mispred_cnt_o), 32'h0);
        chk("rst sat branch_cnt", 32'(bs.branch_cnt_o), 32'h0);
        chk("rst pred no branch", 32'(bi.predict_taken_o), 32'h0);

        //            pc      idb   stall flush exb   upd    rbk   pred  ex     b      m
        vecs[0]  = mk(32'h08, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 16'd0, 16'd0);
        vecs[1]  = mk(32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 2'b11, 16'd1, 16'd0);
        vecs[2]  = mk(32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'b11, 16'd2, 16'd1);
        vecs[3]  = mk(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 16'd2, 16'd1);
        vecs[4]  = mk(32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 16'd3, 16'd2);
        vecs[5]  = mk(32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 16'd4, 16'd2);
        vecs[6]  = mk(32'h08, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 16'd5, 16'd2);
        vecs[7]  = mk(32'h50, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 16'd5, 16'd2);
        vecs[8]  = mk(32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 16'd6, 16'd2);
        vecs[9]  = mk(32'h50, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b10, 16'd6, 16'd2);
        vecs[10] = mk(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 16'd6, 16'd2);
        vecs[11] = mk(32'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 16'd6, 16'd2);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].idb, vecs[i].stall, vecs[i].flush,
                  vecs[i].exb, vecs[i].upd, vecs[i].rbk);
            #1;
            chk($sformatf("v%0d predict", i), 32'(bi.predict_taken_o), 32'(vecs[i].exp_pred));
            sbq.push_back('{ex: vecs[i].exp_ex, b: vecs[i].exp_b, m: vecs[i].exp_m});
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("v%0d ex_state", i), 32'(bi.EX_state_o), 32'(e.ex));
            chk($sformatf("v%0d branch_cnt", i), 32'(bi.branch_cnt_o), 32'(e.b));
            chk($sformatf("v%0d mispred_cnt", i), 32'(bi.mispred_cnt_o), 32'(e.m));
        end

        // Saturation on the narrow-counter instance: five writes, three rollbacks.
        do_reset();
        drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        rbk_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, rbk_pat[k]);
        end
        @(negedge clk);
        drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        #1;
        chk("sat branch_cnt", 32'(bs.branch_cnt_o), 32'h3);
        chk("sat mispred_cnt", 32'(bs.mispred_cnt_o), 32'h3);
        chk("wide branch_cnt", 32'(bi.branch_cnt_o), 32'h5);
        chk("wide mispred_cnt", 32'(bi.mispred_cnt_o), 32'h3);
        chk("pre-reset entry4 state 01", 32'(bi.predict_taken_o), 32'h0);

        // Reset coinciding with a live write: write dropped, table restored.
        @(negedge clk);
        rst_i = 1'b1;
        drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        chk("mid rst branch_cnt", 32'(bi.branch_cnt_o), 32'h0);
        chk("mid rst mispred_cnt", 32'(bi.mispred_cnt_o), 32'h0);
        chk("mid rst sat branch_cnt", 32'(bs.branch_cnt_o), 32'h0);
        chk("mid rst ex_state", 32'(bi.EX_state_o), 32'h3);
        @(negedge clk);
        rst_i = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (j != 0) @(negedge clk);
            drive(32'(j) << 2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
            #1;
            chk($sformatf("post rst pred idx%0d", j), 32'(bi.predict_taken_o), 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("post rst state idx%0d", j), 32'(bi.EX_state_o), 32'h3);
        end
        chk("post rst branch_cnt", 32'(bi.branch_cnt_o), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
